// File: rtl/if_resp_tracker.sv
// Instruction-fetch response tracker: pairs in-order icache responses with request PCs,
// discards responses of flushed requests and buffers live responses while decode stalls.
module if_resp_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FETCH_WIDTH     = 2,
  parameter int PC_WIDTH        = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_fire_i,
  input  logic [PC_WIDTH-1:0]                req_pc_i,
  output logic                               req_allow_o,
  input  logic                               flush_i,
  input  logic                               data_ok_i,
  input  logic [32*FETCH_WIDTH-1:0]          rdata_i,
  input  logic                               next_allowin_i,
  output logic                               out_valid_o,
  output logic [PC_WIDTH-1:0]                out_pc_o,
  output logic [32*FETCH_WIDTH-1:0]          out_inst_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   inflight_o,
  output logic                               error_o
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int DW = 32 * FETCH_WIDTH;
  localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);

  logic [PC_WIDTH-1:0] r_pcMem   [MAX_OUTSTANDING];
  logic [PC_WIDTH-1:0] r_fifoPc  [MAX_OUTSTANDING];
  logic [DW-1:0]       r_fifoInst[MAX_OUTSTANDING];
  logic [AW-1:0]       r_qHead, r_qTail, r_fHead, r_fTail;
  logic [CW-1:0]       r_qCnt, r_cancelCnt, r_fCnt;
  logic                r_error;

  logic          w_qEmpty, w_qFull, w_qPop, w_qPush;
  logic          w_live, w_fEmpty, w_fFull, w_bypass, w_fPush, w_fWrite, w_fPop;
  logic          w_outValid, w_overflow, w_allow;
  logic [CW-1:0] w_qCntNext;

  assign w_qEmpty   = (r_qCnt == '0);
  assign w_qFull    = (r_qCnt == DEPTH);
  assign w_fEmpty   = (r_fCnt == '0);
  assign w_fFull    = (r_fCnt == DEPTH);
  assign w_allow    = ({1'b0, r_qCnt} + {1'b0, r_fCnt}) < {1'b0, DEPTH};
  assign w_qPop     = data_ok_i && !w_qEmpty;
  assign w_qPush    = req_fire_i && (!w_qFull || w_qPop);
  // A response is live only if no older cancelled entries remain and no flush kills it now.
  assign w_live     = w_qPop && (r_cancelCnt == '0) && !flush_i;
  assign w_bypass   = w_live && w_fEmpty && next_allowin_i;
  assign w_fPush    = w_live && !w_bypass;
  assign w_outValid = !flush_i && (!w_fEmpty || w_live);
  assign w_fPop     = w_outValid && next_allowin_i && !w_fEmpty;
  assign w_overflow = w_fPush && w_fFull && !w_fPop;
  assign w_fWrite   = w_fPush && !w_overflow;
  assign w_qCntNext = r_qCnt + CW'(w_qPush) - CW'(w_qPop);

  always_comb begin
    out_valid_o = 1'b0;
    out_pc_o    = '0;
    out_inst_o  = '0;
    if (w_outValid) begin
      out_valid_o = 1'b1;
      if (!w_fEmpty) begin
        out_pc_o   = r_fifoPc[r_fHead];
        out_inst_o = r_fifoInst[r_fHead];
      end else begin
        out_pc_o   = r_pcMem[r_qHead];
        out_inst_o = rdata_i;
      end
    end
  end

  assign req_allow_o = w_allow;
  assign inflight_o  = r_qCnt;
  assign error_o     = r_error;

  always_ff @(posedge clk) begin
    if (w_qPush) r_pcMem[r_qTail] <= req_pc_i;
    if (w_fWrite) begin
      r_fifoPc[r_fTail]   <= r_pcMem[r_qHead];
      r_fifoInst[r_fTail] <= rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_qHead     <= '0;
      r_qTail     <= '0;
      r_qCnt      <= '0;
      r_cancelCnt <= '0;
      r_fHead     <= '0;
      r_fTail     <= '0;
      r_fCnt      <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_qPop)  r_qHead <= r_qHead + 1'b1;
      if (w_qPush) r_qTail <= r_qTail + 1'b1;
      r_qCnt <= w_qCntNext;
      // On flush every entry still queued after this cycle belongs to the dead path.
      if (flush_i)
        r_cancelCnt <= w_qCntNext;
      else if (w_qPop && (r_cancelCnt != '0))
        r_cancelCnt <= r_cancelCnt - 1'b1;
      if (flush_i) begin
        r_fHead <= '0;
        r_fTail <= '0;
        r_fCnt  <= '0;
      end else begin
        if (w_fPop)   r_fHead <= r_fHead + 1'b1;
        if (w_fWrite) r_fTail <= r_fTail + 1'b1;
        r_fCnt <= r_fCnt + CW'(w_fWrite) - CW'(w_fPop);
      end
      if ((data_ok_i && w_qEmpty) || (req_fire_i && !w_allow) || w_overflow)
        r_error <= 1'b1;
    end
  end

endmodule
